// File: rtl/alu_result_pipe.sv
// ---------------------------------------------------------------------------
// alu_result_pipe
//
// EX->WB pipeline slot that follows the 2-input ALU. It holds the ALU result
// with its selector and destination tag, and has a valid/ready handshake on
// both sides. A main register drives the outputs. A skid register absorbs
// one extra result so the ALU never loses data when writeback stalls. The
// zero flag is computed when an entry is written and stored with it.
//
// Parameters:
//   DATA_W      ALU result width
//   TAG_W       destination register index width
//
// Ports:
//   CLK         rising-edge clock
//   RST_N       asynchronous active-low reset
//   in_result   ALU result (OUT_ALU2)
//   in_sel      ALU selector that produced the result
//   in_tag      destination register index
//   in_valid    in_* carries a valid result
//   in_ready    stage can accept this cycle (registered, = !skid_valid)
//   flush       synchronous kill of all held entries
//   out_result  head-entry result
//   out_sel     head-entry selector
//   out_tag     head-entry tag
//   out_zero    head-entry result == 0 (stored flag)
//   out_valid   head entry valid
//   out_ready   consumer accepts head this cycle
//   stall_cnt   [ALU_RESULT_PIPE_STALLCNT_EN only] saturating count of
//               cycles with out_valid && !out_ready, cleared by flush
//
// Optional feature macro: ALU_RESULT_PIPE_STALLCNT_EN
// ---------------------------------------------------------------------------
module alu_result_pipe #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [DATA_W-1:0] in_result,
    input  logic [1:0]        in_sel,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    output logic [DATA_W-1:0] out_result,
    output logic [1:0]        out_sel,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_zero,
    output logic              out_valid,
    input  logic              out_ready
`ifdef ALU_RESULT_PIPE_STALLCNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    logic              main_valid_q,  main_valid_d;
    logic [DATA_W-1:0] main_result_q, main_result_d;
    logic [1:0]        main_sel_q,    main_sel_d;
    logic [TAG_W-1:0]  main_tag_q,    main_tag_d;
    logic              main_zero_q,   main_zero_d;

    logic              skid_valid_q,  skid_valid_d;
    logic [DATA_W-1:0] skid_result_q, skid_result_d;
    logic [1:0]        skid_sel_q,    skid_sel_d;
    logic [TAG_W-1:0]  skid_tag_q,    skid_tag_d;
    logic              skid_zero_q,   skid_zero_d;

    logic accept;
    logic consume;
    logic in_zero;

    // in_ready comes straight from the skid valid flop, so there is no
    // combinational path from out_ready back to the ALU.
    assign accept  = in_valid && !skid_valid_q;
    assign consume = main_valid_q && out_ready;
    assign in_zero = (in_result == '0);

    always_comb begin
        main_valid_d  = main_valid_q;
        main_result_d = main_result_q;
        main_sel_d    = main_sel_q;
        main_tag_d    = main_tag_q;
        main_zero_d   = main_zero_q;
        skid_valid_d  = skid_valid_q;
        skid_result_d = skid_result_q;
        skid_sel_d    = skid_sel_q;
        skid_tag_d    = skid_tag_q;
        skid_zero_d   = skid_zero_q;

        if (flush) begin
            // Flush beats both accept and consume; data may stay stale.
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || consume) begin
            if (skid_valid_q) begin
                // Older skid entry goes first. in_ready was low, so no
                // input can be accepted in this cycle.
                main_valid_d  = 1'b1;
                main_result_d = skid_result_q;
                main_sel_d    = skid_sel_q;
                main_tag_d    = skid_tag_q;
                main_zero_d   = skid_zero_q;
                skid_valid_d  = 1'b0;
            end else begin
                main_valid_d = accept;
                if (accept) begin
                    main_result_d = in_result;
                    main_sel_d    = in_sel;
                    main_tag_d    = in_tag;
                    main_zero_d   = in_zero;
                end
            end
        end else if (accept) begin
            // Main is full and stalled: park the new result in the skid.
            skid_valid_d  = 1'b1;
            skid_result_d = in_result;
            skid_sel_d    = in_sel;
            skid_tag_d    = in_tag;
            skid_zero_d   = in_zero;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            main_valid_q  <= 1'b0;
            main_result_q <= '0;
            main_sel_q    <= '0;
            main_tag_q    <= '0;
            main_zero_q   <= 1'b0;
            skid_valid_q  <= 1'b0;
            skid_result_q <= '0;
            skid_sel_q    <= '0;
            skid_tag_q    <= '0;
            skid_zero_q   <= 1'b0;
        end else begin
            main_valid_q  <= main_valid_d;
            main_result_q <= main_result_d;
            main_sel_q    <= main_sel_d;
            main_tag_q    <= main_tag_d;
            main_zero_q   <= main_zero_d;
            skid_valid_q  <= skid_valid_d;
            skid_result_q <= skid_result_d;
            skid_sel_q    <= skid_sel_d;
            skid_tag_q    <= skid_tag_d;
            skid_zero_q   <= skid_zero_d;
        end
    end

    assign in_ready   = !skid_valid_q;
    assign out_valid  = main_valid_q;
    assign out_result = main_result_q;
    assign out_sel    = main_sel_q;
    assign out_tag    = main_tag_q;
    assign out_zero   = main_zero_q;

`ifdef ALU_RESULT_PIPE_STALLCNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (flush) begin
            stall_d = '0;
        end else if (main_valid_q && !out_ready && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_alu_result_pipe.sv
// ---------------------------------------------------------------------------
// Testbench for alu_result_pipe: a table of directed vectors from the test
// plan, hand-written reset sequences, and randomized traffic checked against
// a queue-based reference model of the two-entry FIFO stage.
// ---------------------------------------------------------------------------
module tb_alu_result_pipe;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [31:0] in_result = '0;
    logic [1:0]  in_sel = '0;
    logic [4:0]  in_tag = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        flush = 1'b0;
    logic [31:0] out_result;
    logic [1:0]  out_sel;
    logic [4:0]  out_tag;
    logic        out_zero;
    logic        out_valid;
    logic        out_ready = 1'b0;
`ifdef ALU_RESULT_PIPE_STALLCNT_EN
    logic [15:0] stall_cnt;
`endif

    alu_result_pipe #(.DATA_W(32), .TAG_W(5)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .in_result  (in_result),
        .in_sel     (in_sel),
        .in_tag     (in_tag),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .flush      (flush),
        .out_result (out_result),
        .out_sel    (out_sel),
        .out_tag    (out_tag),
        .out_zero   (out_zero),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
`ifdef ALU_RESULT_PIPE_STALLCNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: ordered list of held entries, at most two.
    typedef struct {
        logic [31:0] res;
        logic [1:0]  sel;
        logic [4:0]  tag;
    } ent_t;

    ent_t m_q[$];
    int   m_stall = 0;

    task automatic model_edge(input logic v, input logic [31:0] r, input logic [1:0] s,
                              input logic [4:0] t, input logic ordy, input logic fl);
        int   sz;
        ent_t e;
        sz = m_q.size();
        if (fl) begin
            m_q.delete();
            m_stall = 0;
        end else begin
            if (sz > 0 && !ordy && m_stall < 65535) m_stall++;
            if (sz > 0 && ordy) void'(m_q.pop_front());
            if (v && sz < 2) begin
                e.res = r; e.sel = s; e.tag = t;
                m_q.push_back(e);
            end
        end
    endtask

    task automatic model_check();
        chk("m_out_valid", {31'd0, out_valid}, {31'd0, m_q.size() > 0});
        chk("m_in_ready",  {31'd0, in_ready},  {31'd0, m_q.size() < 2});
        if (m_q.size() > 0) begin
            chk("m_out_result", out_result, m_q[0].res);
            chk("m_out_sel",    {30'd0, out_sel}, {30'd0, m_q[0].sel});
            chk("m_out_tag",    {27'd0, out_tag}, {27'd0, m_q[0].tag});
            chk("m_out_zero",   {31'd0, out_zero}, {31'd0, m_q[0].res == 32'd0});
        end
`ifdef ALU_RESULT_PIPE_STALLCNT_EN
        chk("m_stall_cnt", {16'd0, stall_cnt}, m_stall);
`endif
    endtask

    // Drive one cycle of inputs, step the model at the edge, check after it.
    task automatic step(input logic v, input logic [31:0] r, input logic [1:0] s,
                        input logic [4:0] t, input logic ordy, input logic fl);
        in_valid = v; in_result = r; in_sel = s; in_tag = t;
        out_ready = ordy; flush = fl;
        @(posedge CLK);
        model_edge(v, r, s, t, ordy, fl);
        #1;
        model_check();
    endtask

    // Reset asserted between edges must clear outputs immediately.
    task automatic mid_cycle_reset();
        @(posedge CLK);
        #3;
        in_valid = 1'b0; flush = 1'b0;
        RST_N = 1'b0;
        #1;
        chk("rst_out_valid",  {31'd0, out_valid}, 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_zero",   {31'd0, out_zero}, 32'd0);
        chk("rst_in_ready",   {31'd0, in_ready}, 32'd1);
        m_q.delete();
        m_stall = 0;
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    typedef struct {
        logic        v;
        logic [31:0] res;
        logic [1:0]  sel;
        logic [4:0]  tag;
        logic        ordy;
        logic        fl;
        logic        e_ov;
        logic [31:0] e_res;
        logic [1:0]  e_sel;
        logic [4:0]  e_tag;
        logic        e_zero;
        logic        e_ir;
    } vec_t;

    localparam int NV = 21;
    vec_t tbl[NV];

    function automatic vec_t mk(input logic v, input logic [31:0] r, input logic [1:0] s,
                                input logic [4:0] t, input logic ordy, input logic fl,
                                input logic eov, input logic [31:0] eres, input logic [1:0] esel,
                                input logic [4:0] etag, input logic ez, input logic eir);
        vec_t x;
        x.v = v; x.res = r; x.sel = s; x.tag = t; x.ordy = ordy; x.fl = fl;
        x.e_ov = eov; x.e_res = eres; x.e_sel = esel; x.e_tag = etag;
        x.e_zero = ez; x.e_ir = eir;
        return x;
    endfunction

    initial begin
        // Single pass
        tbl[0]  = mk(1, 19, 2'b00, 3, 1, 0,  1, 19, 2'b00, 3, 0, 1);
        tbl[1]  = mk(0,  0, 2'b00, 0, 1, 0,  0,  0, 2'b00, 0, 0, 1);
        // Back-pressure: 19 then 11 fill both slots, 4 is refused
        tbl[2]  = mk(1, 19, 2'b00, 1, 0, 0,  1, 19, 2'b00, 1, 0, 1);
        tbl[3]  = mk(1, 11, 2'b01, 2, 0, 0,  1, 19, 2'b00, 1, 0, 0);
        tbl[4]  = mk(1,  4, 2'b11, 3, 0, 0,  1, 19, 2'b00, 1, 0, 0);
        tbl[5]  = mk(0,  0, 2'b00, 0, 1, 0,  1, 11, 2'b01, 2, 0, 1);
        tbl[6]  = mk(0,  0, 2'b00, 0, 1, 0,  0,  0, 2'b00, 0, 0, 1);
        // Zero flag
        tbl[7]  = mk(1,  0, 2'b10, 4, 1, 0,  1,  0, 2'b10, 4, 1, 1);
        tbl[8]  = mk(1, 15, 2'b00, 5, 1, 0,  1, 15, 2'b00, 5, 0, 1);
        tbl[9]  = mk(0,  0, 2'b00, 0, 1, 0,  0,  0, 2'b00, 0, 0, 1);
        // Flush with both entries full and input offered; then flush of an accept into empty
        tbl[10] = mk(1,  7, 2'b01, 6, 0, 0,  1,  7, 2'b01, 6, 0, 1);
        tbl[11] = mk(1,  8, 2'b10, 7, 0, 0,  1,  7, 2'b01, 6, 0, 0);
        tbl[12] = mk(1,  9, 2'b11, 8, 1, 1,  0,  0, 2'b00, 0, 0, 1);
        tbl[13] = mk(0,  0, 2'b00, 0, 1, 0,  0,  0, 2'b00, 0, 0, 1);
        tbl[14] = mk(1,  5, 2'b00, 9, 1, 1,  0,  0, 2'b00, 0, 0, 1);
        tbl[15] = mk(0,  0, 2'b00, 0, 1, 0,  0,  0, 2'b00, 0, 0, 1);
        // Streaming
        tbl[16] = mk(1, 19, 2'b00, 10, 1, 0, 1, 19, 2'b00, 10, 0, 1);
        tbl[17] = mk(1, 11, 2'b01, 11, 1, 0, 1, 11, 2'b01, 11, 0, 1);
        tbl[18] = mk(1,  4, 2'b10, 12, 1, 0, 1,  4, 2'b10, 12, 0, 1);
        tbl[19] = mk(1, 15, 2'b11, 13, 1, 0, 1, 15, 2'b11, 13, 0, 1);
        tbl[20] = mk(0,  0, 2'b00, 0,  1, 0, 0,  0, 2'b00, 0,  0, 1);

        // Reset state during reset, then release
        #2;
        chk("reset_out_valid",  {31'd0, out_valid}, 32'd0);
        chk("reset_out_result", out_result, 32'd0);
        chk("reset_out_zero",   {31'd0, out_zero}, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        chk("post_reset_in_ready", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < NV; i++) begin
            step(tbl[i].v, tbl[i].res, tbl[i].sel, tbl[i].tag, tbl[i].ordy, tbl[i].fl);
            chk($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].e_ov});
            chk($sformatf("vec%0d_in_ready", i),  {31'd0, in_ready},  {31'd0, tbl[i].e_ir});
            if (tbl[i].e_ov) begin
                chk($sformatf("vec%0d_out_result", i), out_result, tbl[i].e_res);
                chk($sformatf("vec%0d_out_sel", i), {30'd0, out_sel}, {30'd0, tbl[i].e_sel});
                chk($sformatf("vec%0d_out_tag", i), {27'd0, out_tag}, {27'd0, tbl[i].e_tag});
                chk($sformatf("vec%0d_out_zero", i), {31'd0, out_zero}, {31'd0, tbl[i].e_zero});
            end
        end

        // Fill both slots, then reset in the middle of a cycle
        step(1, 32'h1234, 2'b01, 5'd1, 0, 0);
        step(1, 32'h5678, 2'b10, 5'd2, 0, 0);
        mid_cycle_reset();

        // Randomized traffic against the model, with one mid-run reset
        for (int c = 0; c < 600; c++) begin
            logic        v, ordy, fl;
            logic [31:0] r;
            v    = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            fl   = ($urandom_range(0, 19) == 0);
            r    = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            step(v, r, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), ordy, fl);
            if (c == 300) mid_cycle_reset();
        end

        // Long stall to exercise the counter beyond small values
        step(1, 32'd42, 2'b00, 5'd7, 0, 0);
        for (int c = 0; c < 40; c++) step(0, 32'd0, 2'b00, 5'd0, 0, 0);
        step(0, 32'd0, 2'b00, 5'd0, 1, 0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
